// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI serial-clock generator.
// Holds the controller state encoding, default widths and SPI mode codes.
package spi_pkg;

   localparam int DIV_W_DEF = 16;
   localparam int CNT_W_DEF = 6;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      RUN,
      TAIL,
      DONE
   } state_t;

   // Mode code is {cpol, cpha}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   function automatic logic lead_samples(input logic [1:0] mode);
      logic r;
      r = 1'b0;
      case (mode)
         MODE0, MODE2: r = 1'b1;
         MODE1, MODE3: r = 1'b0;
         default:      r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/spi_halfper_timer.sv
// Half-period down-counter: loads on request, counts down while enabled,
// flags expiry at zero and reloads the latched divider in the same cycle.
module spi_halfper_timer
   import spi_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] load_val,
   input  logic             en,
   input  logic [DIV_W-1:0] reload_val,
   output logic             expired
);

   logic [DIV_W-1:0] cnt;

   assign expired = en && (cnt == '0);

   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en) begin
         cnt <= (cnt == '0) ? reload_val : cnt - DIV_W'(1);
      end
   end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: CPOL/CPHA modes, per-transfer bit counting,
// go/busy/done handshake with abort, and registered shift-register strobes.
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             go,
   input  logic             abort,
   input  logic             cpol,
   input  logic             cpha,
   input  logic [DIV_W-1:0] divider,
   input  logic [CNT_W-1:0] nbits,
   output logic             sclk,
   output logic             pos_edge,
   output logic             neg_edge,
   output logic             sample,
   output logic             shift,
   output logic             load,
   output logic             busy,
   output logic             done
);

   state_t state, state_n;

   logic             cpol_l, cpha_l;
   logic [DIV_W-1:0] div_l;
   logic [CNT_W-1:0] nbits_l;

   logic [CNT_W:0] edge_cnt, edge_n, edge_k, last_edge;
   logic           accept, tmr_en, expired, leading, lead_smp;
   logic           sclk_n, pos_n, neg_n, sample_n, shift_n, load_n, busy_n, done_n;

   assign accept    = (state == IDLE) && go && (nbits != '0);
   assign tmr_en    = (state == LEAD) || (state == RUN) || (state == TAIL);
   assign edge_k    = edge_cnt + (CNT_W+1)'(1);
   assign last_edge = {nbits_l, 1'b0};
   assign leading   = edge_k[0];
   assign lead_smp  = lead_samples({cpol_l, cpha_l});

   spi_halfper_timer #(.DIV_W(DIV_W)) u_timer (
      .clk_in     (clk_in),
      .rst        (rst),
      .load       (accept),
      .load_val   (divider),
      .en         (tmr_en),
      .reload_val (div_l),
      .expired    (expired)
   );

   always_comb begin
      state_n  = state;
      edge_n   = edge_cnt;
      sclk_n   = sclk;
      pos_n    = 1'b0;
      neg_n    = 1'b0;
      sample_n = 1'b0;
      shift_n  = 1'b0;
      load_n   = 1'b0;
      busy_n   = busy;
      done_n   = 1'b0;
      case (state)
         IDLE: begin
            sclk_n = cpol;
            edge_n = '0;
            if (accept) begin
               state_n = LEAD;
               busy_n  = 1'b1;
               load_n  = 1'b1;
            end
         end
         LEAD, RUN: begin
            if (expired) begin
               sclk_n   = ~sclk;
               pos_n    = ~sclk;
               neg_n    = sclk;
               edge_n   = edge_k;
               sample_n = (leading == lead_smp);
               // In leading-sample modes the final trailing edge has no next bit to shift
               shift_n  = lead_smp ? (~leading && (edge_k != last_edge)) : leading;
               state_n  = (edge_k == last_edge) ? TAIL : RUN;
            end
         end
         TAIL: begin
            if (expired) begin
               state_n = DONE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
      endcase
      // Abort wins over a same-cycle expiry and suppresses every strobe
      if (abort && (state != IDLE)) begin
         state_n  = IDLE;
         edge_n   = '0;
         sclk_n   = cpol_l;
         pos_n    = 1'b0;
         neg_n    = 1'b0;
         sample_n = 1'b0;
         shift_n  = 1'b0;
         load_n   = 1'b0;
         busy_n   = 1'b0;
         done_n   = 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state    <= IDLE;
         edge_cnt <= '0;
         sclk     <= 1'b0;
         pos_edge <= 1'b0;
         neg_edge <= 1'b0;
         sample   <= 1'b0;
         shift    <= 1'b0;
         load     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         edge_cnt <= edge_n;
         sclk     <= sclk_n;
         pos_edge <= pos_n;
         neg_edge <= neg_n;
         sample   <= sample_n;
         shift    <= shift_n;
         load     <= load_n;
         busy     <= busy_n;
         done     <= done_n;
      end
   end

   always_ff @(posedge clk_in) begin
      if (accept) begin
         cpol_l  <= cpol;
         cpha_l  <= cpha;
         div_l   <= divider;
         nbits_l <= nbits;
      end
   end

endmodule

// File: doc/spi_sclk_gen.md
# spi_sclk_gen

Parametrised SPI serial-clock generator for the SPI master core; successor to the fixed 32-bit divider clock block. Adds all four CPOL/CPHA modes, a built-in per-transfer bit counter, a go/busy/done handshake with abort, and mode-resolved sample/shift/load strobes for the shift register. Sits between the SPI control registers and the SPI shift register.

## Interface
- DIV_W, 16, divider width; SCLK half-period = divider+1 clk_in cycles
- CNT_W, 6, width of nbits; max transfer 2^CNT_W-1 bits
- clk_in  in  1  system clock
- rst  in  1  synchronous, active-high reset
- go  in  1  start request, sampled only in IDLE
- abort  in  1  terminate transfer immediately
- cpol  in  1  idle clock level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- divider  in  DIV_W  half-period minus one
- nbits  in  CNT_W  SCLK cycles (bits) per transfer
- sclk  out  1  serial clock
- pos_edge  out  1  sclk rose this cycle
- neg_edge  out  1  sclk fell this cycle
- sample  out  1  shift register captures MISO this cycle
- shift  out  1  shift register drives next MOSI bit this cycle
- load  out  1  first MOSI bit must be presented (transfer start)
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, LEAD, RUN, TAIL, DONE.
- IDLE: sclk <= cpol every cycle. go=1 with nbits!=0 latches cpol, cpha, divider, nbits -> LEAD; half-period counter loaded with divider. go with nbits=0 ignored.
- Half-period counter decrements each cycle in LEAD/RUN/TAIL; at 0 reloads latched divider and raises an expiry.
- LEAD: expiry -> RUN, sclk toggles (first leading edge).
- RUN: each expiry toggles sclk; edge counter (CNT_W+1 bits) counts edges to 2*nbits. Toggle producing edge 2*nbits -> TAIL.
- TAIL: expiry -> DONE. DONE: done=1 one cycle -> IDLE.
- Leading edge = odd edges (1,3,..), trailing = even edges.
- sample: cpha=0 on leading edges; cpha=1 on trailing edges. nbits pulses per transfer.
- shift: cpha=0 on trailing edges 1..nbits-1 (final trailing edge suppressed); cpha=1 on all nbits leading edges.
- load: one pulse in the first LEAD cycle, both modes.
- go/inputs changed while busy: ignored; latched copies used until IDLE.
- abort (any non-IDLE state): next cycle IDLE, sclk = latched cpol, no done, no strobes that cycle; abort has priority over expiry.
- Reset: sclk=0, all strobes 0, busy=0, done=0, state IDLE, counters 0. Reset mid-transfer behaves identically (no done).

## Timing
- All outputs registered. H = divider+1.
- go high in cycle c: busy=1 and load=1 in c+1.
- Edge k (k=1..2*nbits) visible on sclk in cycle c+1+k*H; pos_edge/neg_edge/sample/shift asserted that same cycle.
- done=1 and busy=0 in cycle c+1+(2*nbits+1)*H; next go accepted in the cycle after done.
- busy and done never simultaneously high. pos_edge and neg_edge mutually exclusive.
- divider=0: sclk toggles every cycle in RUN; strobes every cycle.
- divider=2^DIV_W-1: counter full width, no overflow; width arithmetic unsigned, edge counter compare against {nbits,1'b0}.

## Structure
- Shared package spi_pkg: state enum (IDLE/LEAD/RUN/TAIL/DONE), DIV_W/CNT_W defaults, mode encoding constants (MODE0..MODE3 = {cpol,cpha}).
- Sub-module spi_halfper_timer: DIV_W load/decrement counter with enable, reload and expiry output; instantiated once. FSM, edge counter and strobe decode stay in the top.

## Test plan
- Mode 0, divider=1, nbits=2, go in cycle c -> sclk rises c+3, c+7, falls c+5, c+9; sample at c+3,c+7; shift at c+5 only; load c+1; done c+11.
- Mode 3, divider=1, nbits=2 -> sclk idle 1, falls c+3,c+7, rises c+5,c+9; shift at c+3,c+7; sample at c+5,c+9; done c+11.
- divider=0, nbits=8, mode 1 -> 16 edges on consecutive cycles c+2..c+17, 8 sample pulses on even edges, done c+18.
- abort in cycle of edge 3 (mode 0, divider=3, nbits=4) -> next cycle busy=0, sclk=0, no done, no further strobes; new go accepted immediately.
- go with nbits=0 -> busy stays 0; go while busy with changed divider -> ignored, timing unchanged.
- rst asserted mid-RUN with cpol=1 -> next cycle sclk=0, busy=0, all strobes 0; following idle cycle sclk=1.
